// File: rtl/vga_sync_generator.sv
// VGA sync generator: derives a pixel tick from the rising edge of CRTclock,
// runs the horizontal/vertical counters and decodes the registered sync,
// display-enable and frame-start outputs from the new counter values.
// Optional feature macro: VGA_FRAMECOUNT_EN enables the 8-bit frame counter;
// without it FrameCount is tied to zero.
module vga_sync_generator #(
   parameter int HVisible   = 640,
   parameter int HFront     = 16,
   parameter int HSyncWidth = 96,
   parameter int HBack      = 48,
   parameter int VVisible   = 480,
   parameter int VFront     = 10,
   parameter int VSyncWidth = 2,
   parameter int VBack      = 33
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       CRTclock,
   output logic       HSync,
   output logic       VSync,
   output logic       DisplayEnable,
   output logic [9:0] PixelX,
   output logic [9:0] PixelY,
   output logic       FrameStart,
   output logic [7:0] FrameCount
);

   localparam int HTotal = HVisible + HFront + HSyncWidth + HBack;
   localparam int VTotal = VVisible + VFront + VSyncWidth + VBack;

   localparam logic [9:0] HLast      = 10'(HTotal - 1);
   localparam logic [9:0] VLast      = 10'(VTotal - 1);
   localparam logic [9:0] HVisLimit  = 10'(HVisible);
   localparam logic [9:0] VVisLimit  = 10'(VVisible);
   localparam logic [9:0] HSyncStart = 10'(HVisible + HFront);
   localparam logic [9:0] HSyncEnd   = 10'(HVisible + HFront + HSyncWidth - 1);
   localparam logic [9:0] VSyncStart = 10'(VVisible + VFront);
   localparam logic [9:0] VSyncEnd   = 10'(VVisible + VFront + VSyncWidth - 1);

   // Registered copy of CRTclock; a tick is the cycle where CRTclock is high
   // and this copy is still low, so a long high level yields one tick only.
   logic       crt_q;
   logic       tick;
   logic [9:0] h_next;
   logic [9:0] v_next;
   logic       frame_wrap;

   assign tick       = CRTclock & ~crt_q;
   assign frame_wrap = (h_next == 10'd0) && (v_next == 10'd0);

   // Edge-detect register; reset to 1 so a high CRTclock at release is ignored.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         crt_q <= 1'b1;
      end else begin
         crt_q <= CRTclock;
      end
   end

   // Next counter values: horizontal wraps at the line end and carries into
   // the vertical count, which wraps on the same tick at the frame end.
   always_comb begin
      h_next = PixelX + 10'd1;
      v_next = PixelY;
      if (PixelX == HLast) begin
         h_next = 10'd0;
         if (PixelY == VLast) begin
            v_next = 10'd0;
         end else begin
            v_next = PixelY + 10'd1;
         end
      end
   end

   // Counters and decoded outputs, all updated together from the new counts.
   // Reset parks the counters on the last pixel so the first tick lands on (0,0).
   always_ff @(posedge Clock) begin
      if (Reset) begin
         PixelX        <= HLast;
         PixelY        <= VLast;
         HSync         <= 1'b1;
         VSync         <= 1'b1;
         DisplayEnable <= 1'b0;
         FrameStart    <= 1'b0;
      end else begin
         FrameStart <= tick && frame_wrap;
         if (tick) begin
            PixelX        <= h_next;
            PixelY        <= v_next;
            HSync         <= !((h_next >= HSyncStart) && (h_next <= HSyncEnd));
            VSync         <= !((v_next >= VSyncStart) && (v_next <= VSyncEnd));
            DisplayEnable <= (h_next < HVisLimit) && (v_next < VVisLimit);
         end
      end
   end

`ifdef VGA_FRAMECOUNT_EN
   // Frame counter advances on every frame start and wraps naturally at 8 bits.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         FrameCount <= 8'd0;
      end else if (tick && frame_wrap) begin
         FrameCount <= FrameCount + 8'd1;
      end
   end
`else
   assign FrameCount = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// Directed bench: a default-timing instance checks reset state, the first
// tick and one full line; a reduced-timing instance (15 x 8 totals) makes
// whole frames, frame wrap and mid-frame reset cheap to exercise.
module tb_vga_sync_generator;

   logic       Clock;
   logic       Reset;
   logic       CRTclock;

   logic       a_hsync, a_vsync, a_de, a_fs;
   logic [9:0] a_x, a_y;
   logic [7:0] a_fc;
   logic       b_hsync, b_vsync, b_de, b_fs;
   logic [9:0] b_x, b_y;
   logic [7:0] b_fc;

   int n_assert = 0;
   int n_fail   = 0;

   // Small timing: HTotal = 8+2+3+2 = 15, HSync low at x 10..12;
   // VTotal = 4+1+2+1 = 8, VSync low at y 5..6; 120 ticks per frame.
   vga_sync_generator dut_a (
      .Clock(Clock), .Reset(Reset), .CRTclock(CRTclock),
      .HSync(a_hsync), .VSync(a_vsync), .DisplayEnable(a_de),
      .PixelX(a_x), .PixelY(a_y), .FrameStart(a_fs), .FrameCount(a_fc)
   );

   vga_sync_generator #(
      .HVisible(8), .HFront(2), .HSyncWidth(3), .HBack(2),
      .VVisible(4), .VFront(1), .VSyncWidth(2), .VBack(1)
   ) dut_b (
      .Clock(Clock), .Reset(Reset), .CRTclock(CRTclock),
      .HSync(b_hsync), .VSync(b_vsync), .DisplayEnable(b_de),
      .PixelX(b_x), .PixelY(b_y), .FrameStart(b_fs), .FrameCount(b_fc)
   );

   // Clock generation
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drivers: inputs change on the falling edge, outputs are read there too.
   task automatic do_reset();
      @(negedge Clock);
      Reset    = 1'b1;
      CRTclock = 1'b0;
      repeat (3) @(negedge Clock);
      Reset = 1'b0;
   endtask

   task automatic tick_once();
      @(negedge Clock);
      CRTclock = 1'b1;
      @(negedge Clock);
      CRTclock = 1'b0;
   endtask

   int hs_cnt, hs_first, de_bad, x_bad;
   int ticks, vs_cnt, vs_first_x, vs_first_y, fs_seen;

   initial begin
      Reset    = 1'b1;
      CRTclock = 1'b0;

      // Reset state
      do_reset();
      chk("rst_a_x", 32'(a_x), 32'd799);
      chk("rst_a_y", 32'(a_y), 32'd524);
      chk("rst_a_hsync", 32'(a_hsync), 32'd1);
      chk("rst_a_vsync", 32'(a_vsync), 32'd1);
      chk("rst_a_de", 32'(a_de), 32'd0);
      chk("rst_a_fs", 32'(a_fs), 32'd0);
      chk("rst_a_fc", 32'(a_fc), 32'd0);
      chk("rst_b_x", 32'(b_x), 32'd14);
      chk("rst_b_y", 32'(b_y), 32'd7);

      // CRTclock already high when reset releases: no tick
      @(negedge Clock);
      Reset    = 1'b1;
      CRTclock = 1'b1;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      repeat (3) @(negedge Clock);
      chk("rel_high_x", 32'(a_x), 32'd799);
      chk("rel_high_y", 32'(a_y), 32'd524);
      CRTclock = 1'b0;
      @(negedge Clock);
      chk("rel_low_x", 32'(a_x), 32'd799);

      // First tick after reset lands on (0,0) with FrameStart
      do_reset();
      tick_once();
      chk("first_x", 32'(a_x), 32'd0);
      chk("first_y", 32'(a_y), 32'd0);
      chk("first_fs", 32'(a_fs), 32'd1);
      chk("first_de", 32'(a_de), 32'd1);
      chk("first_hsync", 32'(a_hsync), 32'd1);
      chk("first_vsync", 32'(a_vsync), 32'd1);
      chk("first_b_fs", 32'(b_fs), 32'd1);
`ifdef VGA_FRAMECOUNT_EN
      chk("first_fc", 32'(a_fc), 32'd1);
`else
      chk("first_fc", 32'(a_fc), 32'd0);
`endif
      @(negedge Clock);
      chk("fs_one_cycle", 32'(a_fs), 32'd0);
      chk("hold_x", 32'(a_x), 32'd0);

      // One full line on the default instance
      hs_cnt = 0; hs_first = -1; de_bad = 0; x_bad = 0;
      for (int x = 1; x < 800; x++) begin
         tick_once();
         if (a_x !== 10'(x)) x_bad++;
         if (a_de !== (x < 640)) de_bad++;
         if (a_hsync === 1'b0) begin
            if (hs_cnt == 0) hs_first = x;
            hs_cnt++;
         end
      end
      chk("line_x_track", 32'(x_bad), 32'd0);
      chk("line_hs_width", 32'(hs_cnt), 32'd96);
      chk("line_hs_start", 32'(hs_first), 32'd656);
      chk("line_de", 32'(de_bad), 32'd0);
      chk("line_end_x", 32'(a_x), 32'd799);
      chk("line_end_y", 32'(a_y), 32'd0);
      tick_once();
      chk("line_wrap_x", 32'(a_x), 32'd0);
      chk("line_wrap_y", 32'(a_y), 32'd1);
      chk("line_wrap_fs", 32'(a_fs), 32'd0);

      // CRTclock held high for 10 clocks counts as one tick
      do_reset();
      tick_once();
      @(negedge Clock);
      CRTclock = 1'b1;
      repeat (10) @(negedge Clock);
      CRTclock = 1'b0;
      repeat (2) @(negedge Clock);
      chk("long_high_x", 32'(a_x), 32'd1);
      chk("long_high_y", 32'(a_y), 32'd0);

      // Whole frames on the reduced instance
      do_reset();
      tick_once();
      chk("b_first_fs", 32'(b_fs), 32'd1);
      for (int f = 0; f < 2; f++) begin
         ticks = 0; vs_cnt = 0; vs_first_x = -1; vs_first_y = -1;
         do begin
            tick_once();
            ticks++;
            if (b_vsync === 1'b0) begin
               if (vs_cnt == 0) begin
                  vs_first_x = int'(b_x);
                  vs_first_y = int'(b_y);
               end
               vs_cnt++;
            end
         end while (b_fs !== 1'b1 && ticks < 1000);
         chk("frame_ticks", 32'(ticks), 32'd120);
         chk("frame_vs_width", 32'(vs_cnt), 32'd30);
         chk("frame_vs_x", 32'(vs_first_x), 32'd0);
         chk("frame_vs_y", 32'(vs_first_y), 32'd5);
         chk("frame_wrap_x", 32'(b_x), 32'd0);
         chk("frame_wrap_y", 32'(b_y), 32'd0);
      end
`ifdef VGA_FRAMECOUNT_EN
      chk("fc_three", 32'(b_fc), 32'd3);
      // 254 more frames brings the frame-start total to 257
      fs_seen = 0;
      for (int t = 0; t < 254 * 120; t++) begin
         tick_once();
         if (b_fs === 1'b1) fs_seen++;
      end
      chk("fc_pulses", 32'(fs_seen), 32'd254);
      chk("fc_wrapped", 32'(b_fc), 32'd1);
`else
      chk("fc_off", 32'(b_fc), 32'd0);
`endif

      // Reset mid-frame together with a rising CRTclock
      do_reset();
      for (int t = 0; t < 31; t++) tick_once();
      chk("mid_pre_x", 32'(b_x), 32'd0);
      chk("mid_pre_y", 32'(b_y), 32'd2);
      @(negedge Clock);
      Reset    = 1'b1;
      CRTclock = 1'b1;
      @(negedge Clock);
      chk("mid_b_x", 32'(b_x), 32'd14);
      chk("mid_b_y", 32'(b_y), 32'd7);
      chk("mid_b_hsync", 32'(b_hsync), 32'd1);
      chk("mid_b_fs", 32'(b_fs), 32'd0);
      chk("mid_a_x", 32'(a_x), 32'd799);
      chk("mid_a_y", 32'(a_y), 32'd524);
      Reset    = 1'b0;
      CRTclock = 1'b0;
      repeat (2) @(negedge Clock);
      chk("mid_after_fs", 32'(b_fs), 32'd0);
      chk("mid_after_x", 32'(b_x), 32'd14);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
